// File: rtl/alu_issue_if.sv
// Bundle of the instruction, ALU and result handshakes around the alu_issue sequencer.
// slave is the sequencer's view; master is the environment (source, ALU, result sink).
interface alu_issue_if #(
    parameter int DW = 16
) ();
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [4:0]    alu_f;
    logic [DW-1:0] alu_s;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic [2:0]    res_rd;

    modport slave (
        input  in_valid, in_instr, alu_s, res_ready,
        output in_ready, alu_a, alu_b, alu_f, res_valid, res_data, res_rd
    );

    modport master (
        output in_valid, in_instr, alu_s, res_ready,
        input  in_ready, alu_a, alu_b, alu_f, res_valid, res_data, res_rd
    );
endinterface

// File: rtl/alu_issue.sv
// Issue sequencer for a combinational ALU: IDLE -> RD -> EX -> WB per instruction, 8-entry register file.
// Optional feature: define ALU_ISSUE_TRAP_EN to trap undefined opcodes (adds sticky err output).
module alu_issue #(
    parameter int DW     = 16,
    parameter int REG_AW = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_issue_if.slave bus
`ifdef ALU_ISSUE_TRAP_EN
    ,
    output logic       err
`endif
);
    localparam int NREG = 2 ** REG_AW;

    typedef enum logic [1:0] {IDLE, RD, EX, WB} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          live;
    logic          in_ready;
    logic          accept;

    logic [4:0]    f_q;
    logic [2:0]    rd_q;
    logic [2:0]    ra_q;
    logic          use_imm_q;
    logic [15:0]   imm_q;

    logic [DW-1:0] regs [NREG];
    logic [DW-1:0] alu_a_q;
    logic [DW-1:0] alu_b_q;
    logic [4:0]    alu_f_q;
    logic          res_valid_q;
    logic [DW-1:0] res_data_q;
    logic [2:0]    res_rd_q;

    // Reserved instruction bits carry no meaning.
    logic          unused_rsvd;
    assign unused_rsvd = ^bus.in_instr[19:16];

    // live keeps in_ready low until the first clock after reset release.
    assign accept        = in_ready && bus.in_valid;
    assign bus.in_ready  = in_ready;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_f     = alu_f_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_rd    = res_rd_q;

`ifdef ALU_ISSUE_TRAP_EN
    function automatic logic is_defined_op(input logic [4:0] f);
        return f <= 5'd18;
    endfunction

    logic err_q;
    logic trap;
    assign trap = (state == EX) && !is_defined_op(f_q);
    assign err  = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (trap) begin
            err_q <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            live  <= 1'b0;
        end else begin
            state <= state_nxt;
            live  <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = live;
                if (bus.in_valid && live) state_nxt = RD;
            end
            RD:      state_nxt = EX;
            EX:      state_nxt = WB;
            WB:      if (bus.res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q         <= '0;
            rd_q        <= '0;
            ra_q        <= '0;
            use_imm_q   <= 1'b0;
            imm_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_f_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        f_q       <= bus.in_instr[31:27];
                        rd_q      <= bus.in_instr[26:24];
                        ra_q      <= bus.in_instr[23:21];
                        use_imm_q <= bus.in_instr[20];
                        imm_q     <= bus.in_instr[15:0];
                    end
                end
                RD: begin
                    alu_a_q <= regs[ra_q];
                    alu_b_q <= use_imm_q ? DW'(imm_q) : regs[imm_q[2:0]];
                    alu_f_q <= f_q;
                end
                EX: begin
                    // The ALU output is only trusted here; the write lands before the next RD.
                    res_valid_q <= 1'b1;
                    res_rd_q    <= rd_q;
`ifdef ALU_ISSUE_TRAP_EN
                    if (trap) begin
                        res_data_q <= DW'(16'hDEAD);
                    end else begin
                        res_data_q  <= bus.alu_s;
                        regs[rd_q]  <= bus.alu_s;
                    end
`else
                    res_data_q <= bus.alu_s;
                    regs[rd_q] <= bus.alu_s;
`endif
                end
                WB: begin
                    if (bus.res_ready) res_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural stand-in for the external ALU.
// Build with ALU_ISSUE_TRAP_EN defined to exercise the undefined-opcode trap.
module tb_alu_issue;
    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_MUL = 5'd2;
    localparam logic [4:0] OP_LT  = 5'd12;
    localparam logic [4:0] OP_GE  = 5'd15;
    localparam logic [4:0] OP_BAD = 5'h1F;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alu_issue_if #(.DW(16)) bus ();

`ifdef ALU_ISSUE_TRAP_EN
    logic err;
`endif

    alu_issue #(.DW(16), .REG_AW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ALU_ISSUE_TRAP_EN
        ,
        .err   (err)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in ALU; undefined opcodes return a recognisable pattern.
    function automatic logic [15:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [4:0] f);
        case (f)
            5'd0:    return a + b;
            5'd1:    return a - b;
            5'd2:    return a * b;
            5'd3:    return a & b;
            5'd4:    return a | b;
            5'd5:    return a ^ b;
            5'd6:    return ~a;
            5'd7:    return a << b[3:0];
            5'd8:    return a >> b[3:0];
            5'd9:    return $signed(a) >>> b[3:0];
            5'd10:   return {15'd0, a == b};
            5'd11:   return {15'd0, a != b};
            5'd12:   return {15'd0, a < b};
            5'd13:   return {15'd0, a <= b};
            5'd14:   return {15'd0, a > b};
            5'd15:   return {15'd0, a >= b};
            5'd16:   return {15'd0, (a != 16'd0) && (b != 16'd0)};
            5'd17:   return {15'd0, (a != 16'd0) || (b != 16'd0)};
            5'd18:   return {15'd0, a == 16'd0};
            default: return 16'h5A5A;
        endcase
    endfunction

    always_comb bus.alu_s = alu_model(bus.alu_a, bus.alu_b, bus.alu_f);

    function automatic logic [31:0] enc(input logic [4:0] f, input logic [2:0] rd,
                                        input logic [2:0] ra, input logic ui,
                                        input logic [15:0] imm);
        return {f, rd, ra, ui, 4'h0, imm};
    endfunction

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present an instruction and return 1ns after the accepting edge.
    task automatic accept_instr(input logic [31:0] ins, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_instr = ins;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(32'(bus.in_ready), 32'd1, {tag, "_accept"});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Full instruction with res_ready high: result must appear exactly after edge T+2.
    task automatic run_op(input logic [31:0] ins, input logic [15:0] exp, input string tag);
        logic [2:0] rd;
        rd = ins[26:24];
        accept_instr(ins, tag);
        @(negedge clk);
        @(negedge clk);
        check(32'(bus.res_valid), 32'd0, {tag, "_early"});
        @(negedge clk);
        check(32'(bus.res_valid), 32'd1, {tag, "_valid"});
        check(32'(bus.res_data), 32'(exp), {tag, "_data"});
        check(32'(bus.res_rd), 32'(rd), {tag, "_rd"});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rdy_pat;
        logic [15:0] got [4];
        int          nres;

        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.res_ready = 1'b1;
        rst_n         = 1'b0;

        // Reset values, including in_ready held low until a clock after release.
        #12;
        check(32'(bus.in_ready), 32'd0, "rst_in_ready");
        check(32'(bus.res_valid), 32'd0, "rst_res_valid");
        check(32'(bus.res_data), 32'd0, "rst_res_data");
        check(32'(bus.res_rd), 32'd0, "rst_res_rd");
        check({bus.alu_a, bus.alu_b}, 32'd0, "rst_alu_ab");
        check(32'(bus.alu_f), 32'd0, "rst_alu_f");
        #10;
        rst_n = 1'b1;
        #1;
        check(32'(bus.in_ready), 32'd0, "release_no_clk");
        @(negedge clk);
        check(32'(bus.in_ready), 32'd1, "release_ready");

        // 1: immediate add into R1.
        run_op(enc(OP_ADD, 3'd1, 3'd0, 1'b1, 16'd5), 16'd5, "add_imm");
        check(32'(bus.alu_a), 32'd0, "add_alu_a");
        check(32'(bus.alu_b), 32'd5, "add_alu_b");
        check(32'(bus.alu_f), 32'(OP_ADD), "add_alu_f");

        // 2: register operands, compares; GE carries junk in rsvd and imm[15:3].
        run_op(enc(OP_ADD, 3'd2, 3'd0, 1'b1, 16'd3), 16'd3, "set_r2");
        run_op(enc(OP_SUB, 3'd3, 3'd1, 1'b0, 16'd2), 16'd2, "sub_r1_r2");
        run_op(enc(OP_MUL, 3'd4, 3'd1, 1'b0, 16'd1), 16'd25, "mul_r1_r1");
        run_op(enc(OP_LT, 3'd5, 3'd2, 1'b0, 16'd1), 16'd1, "lt_3_5");
        run_op(enc(OP_GE, 3'd6, 3'd2, 1'b0, 16'hFFF9) | 32'h000F_0000, 16'd0, "ge_3_5");

        // 3: back-to-back R1 = R1 + 1 with in_valid held high.
        @(negedge clk);
        bus.in_instr = enc(OP_ADD, 3'd1, 3'd1, 1'b1, 16'd1);
        bus.in_valid = 1'b1;
        rdy_pat = '0;
        nres = 0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            rdy_pat[i] = bus.in_ready;
            if (bus.res_valid && nres < 4) begin
                got[nres] = bus.res_data;
                nres++;
            end
        end
        bus.in_valid = 1'b0;
        check(32'(rdy_pat), 32'h0000_1111, "b2b_ready_pattern");
        check(32'(nres), 32'd4, "b2b_result_count");
        check(32'(got[0]), 32'd6, "b2b_res0");
        check(32'(got[1]), 32'd7, "b2b_res1");
        check(32'(got[2]), 32'd8, "b2b_res2");
        check(32'(got[3]), 32'd9, "b2b_res3");

        // 4: result backpressure for 10 cycles.
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        accept_instr(enc(OP_ADD, 3'd7, 3'd0, 1'b1, 16'h00AB), "stall");
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check(32'({bus.in_ready, bus.res_valid, bus.res_rd, bus.res_data}),
                  32'({1'b0, 1'b1, 3'd7, 16'h00AB}), "stall_hold");
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        check(32'(bus.res_valid), 32'd0, "stall_release_valid");
        check(32'(bus.in_ready), 32'd1, "stall_release_idle");

        // 5: reset while the instruction is in EX.
        accept_instr(enc(OP_ADD, 3'd4, 3'd0, 1'b1, 16'h0077), "rst_ex");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check(32'(bus.res_valid), 32'd0, "rst_ex_valid");
        check(32'(bus.in_ready), 32'd0, "rst_ex_ready");
        check(32'(bus.res_data), 32'd0, "rst_ex_data");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check(32'(bus.in_ready), 32'd0, "rst_ex_release_no_clk");
        @(negedge clk);
        check(32'(bus.in_ready), 32'd1, "rst_ex_release_ready");
        check(32'(bus.res_valid), 32'd0, "rst_ex_no_result");
        run_op(enc(OP_ADD, 3'd0, 3'd4, 1'b1, 16'd0), 16'd0, "r4_after_rst");
        run_op(enc(OP_ADD, 3'd2, 3'd1, 1'b1, 16'd0), 16'd0, "r1_after_rst");

        // 6: undefined opcode.
        run_op(enc(OP_ADD, 3'd1, 3'd0, 1'b1, 16'h0042), 16'h0042, "r1_set");
`ifdef ALU_ISSUE_TRAP_EN
        check(32'(err), 32'd0, "err_before_trap");
        run_op(enc(OP_BAD, 3'd1, 3'd1, 1'b1, 16'd7), 16'hDEAD, "bad_op_trap");
        check(32'(err), 32'd1, "err_set");
        run_op(enc(OP_ADD, 3'd2, 3'd1, 1'b1, 16'd0), 16'h0042, "r1_unchanged");
        check(32'(err), 32'd1, "err_sticky");
`else
        run_op(enc(OP_BAD, 3'd1, 3'd1, 1'b1, 16'd7), 16'h5A5A, "bad_op_exec");
        run_op(enc(OP_ADD, 3'd2, 3'd1, 1'b1, 16'd0), 16'h5A5A, "r1_written");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
